// File: rtl/layer_sequencer_if.sv
// Stream, broadcast and neuron-capture signals of the layer sequencer.
// The slave modport is the sequencer side; master is the environment side.
interface layer_sequencer_if #(
  parameter int numNeuron = 30,
  parameter int dataWidth = 16
);
  logic [dataWidth-1:0]           in_data;
  logic                           in_valid;
  logic                           in_ready;
  logic [dataWidth-1:0]           myInput;
  logic                           myInputValid;
  logic [numNeuron*dataWidth-1:0] neuron_out;
  logic [numNeuron-1:0]           neuron_outvalid;
  logic [dataWidth-1:0]           out_data;
  logic                           out_valid;
  logic                           out_last;
  logic                           out_ready;
  logic                           busy;
  logic                           layer_done;
  logic                           err_proto;
  logic                           err_timeout;

  modport slave (
    input  in_data, in_valid, neuron_out, neuron_outvalid, out_ready,
    output in_ready, myInput, myInputValid, out_data, out_valid, out_last,
           busy, layer_done, err_proto, err_timeout
  );

  modport master (
    output in_data, in_valid, neuron_out, neuron_outvalid, out_ready,
    input  in_ready, myInput, myInputValid, out_data, out_valid, out_last,
           busy, layer_done, err_proto, err_timeout
  );
endinterface

// File: rtl/layer_sequencer.sv
// Fully-connected layer sequencer: streams activations to a neuron bank,
// captures each neuron's result once, then serializes the results downstream.
//
//   state  | meaning
//   IDLE   | ready for the first activation of an inference
//   STREAM | accepting and broadcasting the remaining activations
//   WAIT   | collecting neuron outvalid pulses, bounded by timeoutCycles
//   DRAIN  | emitting captured results in neuron index order
module layer_sequencer #(
  parameter int numNeuron     = 30,
  parameter int numWeight     = 784,
  parameter int dataWidth     = 16,
  parameter int timeoutCycles = 64
) (
  input  logic               clk,
  input  logic               rst,
  layer_sequencer_if.slave   bus
);
  localparam int CNT_W  = $clog2(numWeight + 1);
  localparam int IDX_W  = $clog2(numNeuron);
  localparam int WAIT_W = $clog2(timeoutCycles);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(numWeight - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(numNeuron - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(timeoutCycles - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_DRAIN} state_t;

  state_t               state;
  logic [CNT_W-1:0]     in_cnt;
  logic [IDX_W-1:0]     out_idx;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [numNeuron-1:0] flags;
  logic [dataWidth-1:0] buffer [numNeuron];

  logic                 in_ready_r, my_input_valid_r, out_valid_r, out_last_r;
  logic                 busy_r, layer_done_r, err_proto_r, err_timeout_r;
  logic [dataWidth-1:0] my_input_r, out_data_r;

  logic                 in_xfer, last_beat, cap_en, proto_hit, all_flags;
  logic [numNeuron-1:0] new_cap;
  logic [IDX_W-1:0]     idx_nxt;

  // The final input beat opens the capture window on its own edge, so pulses
  // arriving together with the WAIT transition are kept rather than flagged.
  always_comb begin
    in_xfer   = bus.in_valid && in_ready_r;
    last_beat = in_xfer && (in_cnt == LAST_CNT);
    cap_en    = (state == S_WAIT) || last_beat;
    new_cap   = cap_en ? (bus.neuron_outvalid & ~flags) : '0;
    proto_hit = cap_en ? |(bus.neuron_outvalid & flags) : |bus.neuron_outvalid;
    all_flags = &flags;
    idx_nxt   = out_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < numNeuron; i++)
      if (new_cap[i]) buffer[i] <= bus.neuron_out[i*dataWidth +: dataWidth];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      in_cnt           <= '0;
      out_idx          <= '0;
      wait_cnt         <= '0;
      flags            <= '0;
      in_ready_r       <= 1'b0;
      my_input_r       <= '0;
      my_input_valid_r <= 1'b0;
      out_data_r       <= '0;
      out_valid_r      <= 1'b0;
      out_last_r       <= 1'b0;
      busy_r           <= 1'b0;
      layer_done_r     <= 1'b0;
      err_proto_r      <= 1'b0;
      err_timeout_r    <= 1'b0;
    end else begin
      my_input_valid_r <= in_xfer;
      if (in_xfer) my_input_r <= bus.in_data;
      layer_done_r <= 1'b0;
      flags        <= flags | new_cap;
      if (proto_hit) err_proto_r <= 1'b1;

      case (state)
        S_IDLE, S_STREAM: begin
          in_ready_r <= 1'b1;
          if (in_xfer) begin
            in_cnt <= in_cnt + 1'b1;
            busy_r <= 1'b1;
            if (last_beat) begin
              state      <= S_WAIT;
              in_ready_r <= 1'b0;
            end else begin
              state <= S_STREAM;
            end
          end
        end
        S_WAIT: begin
          if (all_flags) begin
            state       <= S_DRAIN;
            wait_cnt    <= '0;
            in_cnt      <= '0;
            out_idx     <= '0;
            out_data_r  <= buffer[0];
            out_valid_r <= 1'b1;
            out_last_r  <= 1'b0;
          end else if (wait_cnt == WAIT_MAX) begin
            state         <= S_IDLE;
            err_timeout_r <= 1'b1;
            flags         <= '0;
            wait_cnt      <= '0;
            in_cnt        <= '0;
            busy_r        <= 1'b0;
            in_ready_r    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (bus.out_ready) begin
            if (out_last_r) begin
              state        <= S_IDLE;
              layer_done_r <= 1'b1;
              out_idx      <= '0;
              flags        <= '0;
              out_valid_r  <= 1'b0;
              out_last_r   <= 1'b0;
              busy_r       <= 1'b0;
              in_ready_r   <= 1'b1;
            end else begin
              out_idx    <= idx_nxt;
              out_data_r <= buffer[idx_nxt];
              out_last_r <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.myInput      = my_input_r;
  assign bus.myInputValid = my_input_valid_r;
  assign bus.out_data     = out_data_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_last     = out_last_r;
  assign bus.busy         = busy_r;
  assign bus.layer_done   = layer_done_r;
  assign bus.err_proto    = err_proto_r;
  assign bus.err_timeout  = err_timeout_r;
endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer with a small result model:
// first in-window pulse per neuron wins, results come out in index order.
module tb_layer_sequencer;
  localparam int NN = 4;
  localparam int NW = 8;
  localparam int DW = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  layer_sequencer_if #(.numNeuron(NN), .dataWidth(DW)) bus();

  layer_sequencer #(.numNeuron(NN), .numWeight(NW), .dataWidth(DW), .timeoutCycles(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int failures = 0;

  logic [2*DW+7:0] outs;
  assign outs = {bus.in_ready, bus.myInput, bus.myInputValid, bus.out_data, bus.out_valid,
                 bus.out_last, bus.busy, bus.layer_done, bus.err_proto, bus.err_timeout};

  // reference model state
  logic [DW-1:0] in_vals [NW];
  logic [DW-1:0] exp_res [NN];
  bit            seen [NN];
  bit            exp_proto;

  // monitor state (written only by the monitor)
  int cyc = 0;
  int n_xfer = 0, n_bcast = 0, bcast_err = 0, hold_err = 0, n_outvalid = 0, n_done = 0;
  logic [DW-1:0] out_q [$];
  bit            last_q [$];
  bit            prev_xfer = 0, prev_stall = 0;
  logic [DW-1:0] prev_data, prev_out;

  // bases recorded by the test sequence
  int b_xfer, b_bcast, b_berr, b_herr, b_outvalid, b_done, b_out, last_edge;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_xfer  = 0;
      prev_stall = 0;
    end else begin
      if (prev_xfer) begin
        if (!(bus.myInputValid === 1'b1 && bus.myInput === prev_data)) bcast_err++;
      end else if (bus.myInputValid !== 1'b0) bcast_err++;
      if (bus.myInputValid === 1'b1) n_bcast++;
      prev_xfer = (bus.in_valid && bus.in_ready);
      prev_data = bus.in_data;
      if (prev_xfer) n_xfer++;
      if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_out)) hold_err++;
      prev_stall = (bus.out_valid && !bus.out_ready);
      prev_out   = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        out_q.push_back(bus.out_data);
        last_q.push_back(bus.out_last);
      end
      if (bus.out_valid === 1'b1) n_outvalid++;
      if (bus.layer_done === 1'b1) n_done++;
    end
  end

  task automatic mark();
    b_xfer = n_xfer; b_bcast = n_bcast; b_berr = bcast_err; b_herr = hold_err;
    b_outvalid = n_outvalid; b_done = n_done; b_out = out_q.size();
    for (int i = 0; i < NN; i++) seen[i] = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.neuron_outvalid = '0; bus.out_ready = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    exp_proto = 0;
    mark();
  endtask

  task automatic rand_inputs();
    for (int b = 0; b < NW; b++) in_vals[b] = DW'($urandom);
  endtask

  task automatic stream(input bit gaps, input int pulse_at);
    bit ok;
    for (int b = 0; b < NW; b++) begin
      ok = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = in_vals[b];
      if (b == pulse_at) begin bus.neuron_outvalid[2] = 1'b1; exp_proto = 1; end
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (bus.in_ready === 1'b1) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      last_edge = cyc;
      bus.neuron_outvalid = '0;
      if (!ok) begin
        checks++; failures++;
        $display("FAIL stream_ready: beat %0d saw in_ready=0, required 1 within 20 cycles", b);
      end
      if (gaps) begin bus.in_valid = 1'b0; wait_cycles(1); end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse(input logic [NN-1:0] mask, input logic [NN*DW-1:0] vals, input bit in_wait);
    bus.neuron_out = vals;
    bus.neuron_outvalid = mask;
    for (int i = 0; i < NN; i++)
      if (mask[i]) begin
        if (!in_wait || seen[i]) exp_proto = 1;
        else begin seen[i] = 1; exp_res[i] = vals[i*DW +: DW]; end
      end
    @(posedge clk); #1;
    bus.neuron_outvalid = '0;
  endtask

  function automatic logic [NN*DW-1:0] rand_vals();
    logic [NN*DW-1:0] v;
    for (int i = 0; i < NN; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic drain(input int stall_at, input int stall_len, input bit rnd);
    int start, stalled;
    bit ok;
    start = n_done; stalled = 0; ok = 0;
    for (int t = 0; t < 200; t++) begin
      if ((out_q.size() - b_out) == stall_at && stalled < stall_len) begin
        bus.out_ready = 1'b0; stalled++;
      end else if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      else bus.out_ready = 1'b1;
      @(negedge clk); #1;
      if (n_done != start) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL drain_done: no layer_done within 200 cycles, required one pulse");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.neuron_out = '0;
    bus.neuron_outvalid = '0; bus.out_ready = 1'b1;
    wait_cycles(2);
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs: got %h, required 0", outs); end
    rst = 1'b0;
    wait_cycles(1);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_idle: in_ready=%b busy=%b, required 1 0", bus.in_ready, bus.busy);
    end
    exp_proto = 0;
    mark();
  endtask

  task automatic test_nominal();
    do_reset();
    for (int b = 0; b < NW; b++) in_vals[b] = DW'(b + 1);
    stream(0, -1);
    wait_cycles(2);
    for (int i = 0; i < NN; i++)
      pulse(NN'(1 << i), {16'h0044, 16'h0033, 16'h0022, 16'h0011}, 1);
    drain(-1, 0, 0);
    checks++;
    if ((n_bcast - b_bcast) != NW || (bcast_err - b_berr) != 0) begin
      failures++; $display("FAIL nominal_bcast: pulses=%0d errors=%0d, required %0d 0", n_bcast - b_bcast, bcast_err - b_berr, NW);
    end
    checks++;
    if ((out_q.size() - b_out) != NN) begin failures++; $display("FAIL nominal_count: got %0d results, required %0d", out_q.size() - b_out, NN); end
    for (int i = 0; i < NN && b_out + i < out_q.size(); i++) begin
      checks++;
      if (out_q[b_out+i] !== exp_res[i] || last_q[b_out+i] !== (i == NN-1)) begin
        failures++; $display("FAIL nominal_result[%0d]: got %h last=%b, required %h last=%b", i, out_q[b_out+i], last_q[b_out+i], exp_res[i], i == NN-1);
      end
    end
    checks++;
    if ((n_done - b_done) != 1 || bus.busy !== 1'b0 || bus.err_proto !== 1'b0 || bus.err_timeout !== 1'b0) begin
      failures++; $display("FAIL nominal_end: done=%0d busy=%b errp=%b errt=%b, required 1 0 0 0", n_done - b_done, bus.busy, bus.err_proto, bus.err_timeout);
    end
  endtask

  task automatic test_gaps_backpressure();
    do_reset();
    rand_inputs();
    stream(1, -1);
    bus.in_valid = 1'b1; bus.in_data = DW'($urandom);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL ninth_beat_ready: got %b, required 0", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if ((n_xfer - b_xfer) != NW) begin failures++; $display("FAIL ninth_beat_xfer: got %0d transfers, required %0d", n_xfer - b_xfer, NW); end
    for (int i = 0; i < NN; i++) begin
      wait_cycles($urandom_range(0, 1));
      pulse(NN'(1 << i), rand_vals(), 1);
    end
    drain(1, 3, 0);
    checks++;
    if ((hold_err - b_herr) != 0 || (bcast_err - b_berr) != 0) begin
      failures++; $display("FAIL stall_hold: hold errors=%0d bcast errors=%0d, required 0 0", hold_err - b_herr, bcast_err - b_berr);
    end
    checks++;
    if ((out_q.size() - b_out) != NN) begin failures++; $display("FAIL stall_count: got %0d results, required %0d", out_q.size() - b_out, NN); end
    for (int i = 0; i < NN && b_out + i < out_q.size(); i++) begin
      checks++;
      if (out_q[b_out+i] !== exp_res[i]) begin
        failures++; $display("FAIL stall_result[%0d]: got %h, required %h", i, out_q[b_out+i], exp_res[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    rand_inputs();
    stream(0, -1);
    wait_cycles(1);
    pulse('1, rand_vals(), 1);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL simul_early: out_valid=%b, required 0", bus.out_valid); end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_res[0]) begin
      failures++; $display("FAIL simul_drain_entry: out_valid=%b data=%h, required 1 %h", bus.out_valid, bus.out_data, exp_res[0]);
    end
    @(posedge clk); #1;
    drain(-1, 0, 0);
    checks++;
    if ((out_q.size() - b_out) != NN) begin failures++; $display("FAIL simul_count: got %0d results, required %0d", out_q.size() - b_out, NN); end
    for (int i = 0; i < NN && b_out + i < out_q.size(); i++) begin
      checks++;
      if (out_q[b_out+i] !== exp_res[i] || last_q[b_out+i] !== (i == NN-1)) begin
        failures++; $display("FAIL simul_result[%0d]: got %h last=%b, required %h last=%b", i, out_q[b_out+i], last_q[b_out+i], exp_res[i], i == NN-1);
      end
    end
  endtask

  task automatic test_protocol();
    logic [NN*DW-1:0] v;
    do_reset();
    rand_inputs();
    stream(0, 3);
    @(negedge clk);
    checks++;
    if (bus.err_proto !== 1'b1) begin failures++; $display("FAIL proto_stream: err_proto=%b, required 1", bus.err_proto); end
    @(posedge clk); #1;
    v = rand_vals();
    v[DW +: DW] = 16'h0101;
    pulse(NN'(2), v, 1);
    v[DW +: DW] = 16'h0202;
    pulse(NN'(2), v, 1);
    pulse(NN'(13), rand_vals(), 1);
    drain(-1, 0, 0);
    checks++;
    if (bus.err_proto !== exp_proto) begin failures++; $display("FAIL proto_sticky: err_proto=%b, required %b", bus.err_proto, exp_proto); end
    checks++;
    if ((out_q.size() - b_out) != NN) begin failures++; $display("FAIL proto_count: got %0d results, required %0d", out_q.size() - b_out, NN); end
    for (int i = 0; i < NN && b_out + i < out_q.size(); i++) begin
      checks++;
      if (out_q[b_out+i] !== exp_res[i]) begin
        failures++; $display("FAIL proto_result[%0d]: got %h, required %h", i, out_q[b_out+i], exp_res[i]);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    rand_inputs();
    stream(0, -1);
    pulse(NN'(7), rand_vals(), 1);
    for (int t = 0; t < 100 && cyc < last_edge + TO - 1; t++) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if (bus.err_timeout !== 1'b0 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL timeout_early: err_timeout=%b busy=%b, required 0 1", bus.err_timeout, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.err_timeout !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL timeout_flag: err_timeout=%b busy=%b in_ready=%b, required 1 0 1", bus.err_timeout, bus.busy, bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ((n_outvalid - b_outvalid) != 0) begin failures++; $display("FAIL timeout_no_output: out_valid cycles=%0d, required 0", n_outvalid - b_outvalid); end
    mark();
    rand_inputs();
    stream(0, -1);
    pulse('1, rand_vals(), 1);
    drain(-1, 0, 0);
    checks++;
    if ((out_q.size() - b_out) != NN || bus.err_timeout !== 1'b1 || bus.err_proto !== 1'b0) begin
      failures++; $display("FAIL timeout_rerun: results=%0d errt=%b errp=%b, required %0d 1 0", out_q.size() - b_out, bus.err_timeout, bus.err_proto, NN);
    end
    for (int i = 0; i < NN && b_out + i < out_q.size(); i++) begin
      checks++;
      if (out_q[b_out+i] !== exp_res[i]) begin
        failures++; $display("FAIL timeout_rerun_result[%0d]: got %h, required %h", i, out_q[b_out+i], exp_res[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int s;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      mark();
      rand_inputs();
      stream(1'($urandom_range(0, 1)), -1);
      s = $urandom_range(0, NN-1);
      for (int k = 0; k < NN; k++) begin
        wait_cycles($urandom_range(0, 2));
        pulse(NN'(1 << ((s + k) % NN)), rand_vals(), 1);
      end
      drain(-1, 0, 1);
      checks++;
      if ((out_q.size() - b_out) != NN || (n_done - b_done) != 1 || (hold_err - b_herr) != 0 || (bcast_err - b_berr) != 0) begin
        failures++; $display("FAIL b2b_run%0d: results=%0d done=%0d hold_err=%0d bcast_err=%0d, required %0d 1 0 0", r, out_q.size() - b_out, n_done - b_done, hold_err - b_herr, bcast_err - b_berr, NN);
      end
      for (int i = 0; i < NN && b_out + i < out_q.size(); i++) begin
        checks++;
        if (out_q[b_out+i] !== exp_res[i] || last_q[b_out+i] !== (i == NN-1)) begin
          failures++; $display("FAIL b2b_result[%0d][%0d]: got %h last=%b, required %h last=%b", r, i, out_q[b_out+i], last_q[b_out+i], exp_res[i], i == NN-1);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    rand_inputs();
    stream(0, -1);
    pulse('1, rand_vals(), 1);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk); #1;
      if ((out_q.size() - b_out) >= 2) break;
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL midop_reset_outputs: got %h, required 0", outs); end
    wait_cycles(2);
    rst = 1'b0;
    checks++;
    if ((out_q.size() - b_out) != 2) begin failures++; $display("FAIL midop_partial: got %0d results, required 2", out_q.size() - b_out); end
    exp_proto = 0;
    mark();
    rand_inputs();
    stream(0, -1);
    pulse('1, rand_vals(), 1);
    drain(-1, 0, 0);
    checks++;
    if ((out_q.size() - b_out) != NN || (n_done - b_done) != 1) begin
      failures++; $display("FAIL midop_rerun: results=%0d done=%0d, required %0d 1", out_q.size() - b_out, n_done - b_done, NN);
    end
    for (int i = 0; i < NN && b_out + i < out_q.size(); i++) begin
      checks++;
      if (out_q[b_out+i] !== exp_res[i]) begin
        failures++; $display("FAIL midop_result[%0d]: got %h, required %h", i, out_q[b_out+i], exp_res[i]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.neuron_out = '0;
    bus.neuron_outvalid = '0; bus.out_ready = 1'b1;
    test_reset();
    test_nominal();
    test_gaps_backpressure();
    test_simultaneous();
    test_protocol();
    test_timeout();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
